// File: rtl/uart_cap_scheduler.sv
// uart_cap_scheduler: reads bytes from the RX FIFO, upper-cases ASCII
// letters, optionally follows each CR with an LF, and hands every byte to the
// UART transmitter over a valid/ready handshake. It also counts the bytes the
// transmitter has accepted.
module uart_cap_scheduler #(
  parameter int EXPAND_CR = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    SEND_LF = 3'd4
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  state_t state;
  logic   handshake;

  // Only a-z (0x61..0x7A) move down by 0x20; every other byte passes through.
  function automatic logic [7:0] cap(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end
    return b;
  endfunction

  // The read strobe is decoded from FETCH, so it lasts exactly one cycle and
  // is only reachable after a non-empty FIFO was sampled.
  assign fifo_rd_en = (state == FETCH);
  assign busy       = (state != IDLE);
  assign handshake  = tx_valid & tx_ready;

  // Main sequencer: state, the byte held for TX, and the accepted-byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      byte_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !fifo_empty) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          // FIFO data appears next cycle; pick it up in LATCH.
          state <= LATCH;
        end
        LATCH: begin
          tx_data  <= cap(fifo_rd_data);
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND, SEND_LF: begin
          // tx_data/tx_valid hold until the transmitter takes the byte.
          if (handshake) begin
            byte_count <= byte_count + CNT_W'(1);
            if (state == SEND && EXPAND_CR != 0 && tx_data == CR) begin
              // Keep valid high and present the inserted LF right away.
              tx_data <= LF;
              state   <= SEND_LF;
            end else if (en && !fifo_empty) begin
              tx_valid <= 1'b0;
              state    <= FETCH;
            end else begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cap_scheduler.sv
// Directed bench for uart_cap_scheduler. Three instances share clock, reset,
// enable and tx_ready: #0 is the default build, #1 has CR expansion off and
// #2 has a 4-bit byte counter. Each instance has its own model FIFO.
module tb_uart_cap_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic tx_ready;

  logic       fe     [3];
  logic       rd_en  [3];
  logic [7:0] rdd    [3];
  logic [7:0] txd    [3];
  logic       txv    [3];
  logic       bsy    [3];
  logic [15:0] cnt0;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  // model FIFOs: written by the stimulus, read by the DUT strobe
  logic [7:0] mem [3][32];
  logic [4:0] wp  [3] = '{5'd0, 5'd0, 5'd0};
  logic [4:0] rp  [3] = '{5'd0, 5'd0, 5'd0};
  int         rdcnt [3] = '{0, 0, 0};
  int         cyc = 0;

  logic [7:0] got0 [$];
  logic [7:0] got1 [$];
  logic [7:0] got2 [$];
  int         stamp0 [$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_cap_scheduler #(.EXPAND_CR(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fe[0]), .fifo_rd_en(rd_en[0]),
    .fifo_rd_data(rdd[0]), .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
    .byte_count(cnt0), .busy(bsy[0]));

  uart_cap_scheduler #(.EXPAND_CR(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fe[1]), .fifo_rd_en(rd_en[1]),
    .fifo_rd_data(rdd[1]), .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
    .byte_count(cnt1), .busy(bsy[1]));

  uart_cap_scheduler #(.EXPAND_CR(1), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_empty(fe[2]), .fifo_rd_en(rd_en[2]),
    .fifo_rd_data(rdd[2]), .tx_data(txd[2]), .tx_valid(txv[2]), .tx_ready(tx_ready),
    .byte_count(cnt2), .busy(bsy[2]));

  // FIFO empty flags follow the pointers
  always_comb begin
    for (int i = 0; i < 3; i++) fe[i] = (wp[i] == rp[i]);
  end

  // FIFO read port, cycle counter and TX acceptance monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i]) begin
        rdd[i]   <= mem[i][rp[i]];
        rp[i]    <= rp[i] + 5'd1;
        rdcnt[i] <= rdcnt[i] + 1;
      end
    end
    if (txv[0] && tx_ready) begin
      got0.push_back(txd[0]);
      stamp0.push_back(cyc);
      $display("[%0d] dut0 tx accept %02h", cyc, txd[0]);
    end
    if (txv[1] && tx_ready) begin
      got1.push_back(txd[1]);
      $display("[%0d] dut1 tx accept %02h", cyc, txd[1]);
    end
    if (txv[2] && tx_ready) begin
      got2.push_back(txd[2]);
      $display("[%0d] dut2 tx accept %02h", cyc, txd[2]);
    end
  end

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i]] = b;
    wp[i] = wp[i] + 5'd1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    push(0, 8'h61);
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (txv[0] !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid got %b want 0", txv[0]); end
    n_cmp++; if (txd[0] !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data got %02h want 00", txd[0]); end
    n_cmp++; if (cnt0 !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cnt0); end
    n_cmp++; if (bsy[0] !== 1'b0 || rd_en[0] !== 1'b0) begin n_bad++; $display("FAIL reset_busy_rd got %b%b want 00", bsy[0], rd_en[0]); end
    rst_n = 1'b1;
    @(negedge clk);  // IDLE sampled non-empty FIFO at the edge just passed
    n_cmp++; if (rd_en[0] !== 1'b1 || bsy[0] !== 1'b1) begin n_bad++; $display("FAIL first_fetch got rd=%b busy=%b want 1 1", rd_en[0], bsy[0]); end
    @(negedge clk);
    n_cmp++; if (rd_en[0] !== 1'b0 || txv[0] !== 1'b0) begin n_bad++; $display("FAIL latch_cycle got rd=%b valid=%b want 0 0", rd_en[0], txv[0]); end
    @(negedge clk);
    n_cmp++; if (txv[0] !== 1'b1 || txd[0] !== 8'h41) begin n_bad++; $display("FAIL first_send got valid=%b data=%02h want 1 41", txv[0], txd[0]); end
    tx_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL first_count got %0d want 1", cnt0); end
    n_cmp++; if (txv[0] !== 1'b0 || bsy[0] !== 1'b0) begin n_bad++; $display("FAIL first_idle got valid=%b busy=%b want 0 0", txv[0], bsy[0]); end
    n_cmp++; if (rdcnt[0] !== 1) begin n_bad++; $display("FAIL first_rd_pulses got %0d want 1", rdcnt[0]); end
  endtask

  task automatic test_stream;
    logic [7:0] exp_b [5] = '{8'h41, 8'h5A, 8'h7B, 8'h60, 8'h7E};
    logic [7:0] in_b  [5] = '{8'h61, 8'h5A, 8'h7B, 8'h60, 8'h7E};
    int s = got0.size();
    logic [15:0] c = cnt0;
    tx_ready = 1'b1;
    for (int j = 0; j < 5; j++) push(0, in_b[j]);
    for (int k = 0; k < 100 && got0.size() < s + 5; k++) @(negedge clk);
    n_cmp++; if (got0.size() !== s + 5) begin n_bad++; $display("FAIL stream_len got %0d want %0d", got0.size() - s, 5); end
    else begin
      for (int j = 0; j < 5; j++) begin
        n_cmp++; if (got0[s+j] !== exp_b[j]) begin n_bad++; $display("FAIL stream_byte%0d got %02h want %02h", j, got0[s+j], exp_b[j]); end
      end
      for (int j = 1; j < 5; j++) begin
        n_cmp++; if (stamp0[s+j] - stamp0[s+j-1] !== 3) begin n_bad++; $display("FAIL stream_gap%0d got %0d want 3", j, stamp0[s+j] - stamp0[s+j-1]); end
      end
    end
    @(negedge clk);
    n_cmp++; if (cnt0 !== c + 16'd5) begin n_bad++; $display("FAIL stream_count got %0d want %0d", cnt0, c + 16'd5); end
    n_cmp++; if (bsy[0] !== 1'b0) begin n_bad++; $display("FAIL stream_busy got %b want 0", bsy[0]); end
  endtask

  task automatic test_cr_expand;
    int s0 = got0.size();
    int s1 = got1.size();
    logic [15:0] c0 = cnt0;
    logic [15:0] c1 = cnt1;
    tx_ready = 1'b1;
    push(0, 8'h0D); push(0, 8'h62);
    push(1, 8'h0D); push(1, 8'h62);
    for (int k = 0; k < 100 && (got0.size() < s0 + 3 || got1.size() < s1 + 2); k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++; if (got0.size() !== s0 + 3) begin n_bad++; $display("FAIL cr_len_on got %0d want 3", got0.size() - s0); end
    else begin
      n_cmp++; if (got0[s0] !== 8'h0D || got0[s0+1] !== 8'h0A || got0[s0+2] !== 8'h42) begin
        n_bad++; $display("FAIL cr_bytes_on got %02h %02h %02h want 0d 0a 42", got0[s0], got0[s0+1], got0[s0+2]);
      end
    end
    n_cmp++; if (got1.size() !== s1 + 2) begin n_bad++; $display("FAIL cr_len_off got %0d want 2", got1.size() - s1); end
    else begin
      n_cmp++; if (got1[s1] !== 8'h0D || got1[s1+1] !== 8'h42) begin
        n_bad++; $display("FAIL cr_bytes_off got %02h %02h want 0d 42", got1[s1], got1[s1+1]);
      end
    end
    n_cmp++; if (cnt0 !== c0 + 16'd3) begin n_bad++; $display("FAIL cr_count_on got %0d want %0d", cnt0, c0 + 16'd3); end
    n_cmp++; if (cnt1 !== c1 + 16'd2) begin n_bad++; $display("FAIL cr_count_off got %0d want %0d", cnt1, c1 + 16'd2); end
    n_cmp++; if (bsy[1] !== 1'b0) begin n_bad++; $display("FAIL cr_busy_off got %b want 0", bsy[1]); end
  endtask

  task automatic test_backpressure;
    int s;
    int r;
    tx_ready = 1'b0;
    push(0, 8'h71); push(0, 8'h61);
    for (int k = 0; k < 20 && txv[0] !== 1'b1; k++) @(negedge clk);
    n_cmp++; if (txv[0] !== 1'b1) begin n_bad++; $display("FAIL bp_valid_timeout got %b want 1", txv[0]); end
    s = got0.size();
    r = rdcnt[0];
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++; if (txv[0] !== 1'b1 || txd[0] !== 8'h51) begin
        n_bad++; $display("FAIL bp_hold cycle %0d got valid=%b data=%02h want 1 51", k, txv[0], txd[0]);
      end
    end
    n_cmp++; if (rdcnt[0] !== r) begin n_bad++; $display("FAIL bp_no_fetch got %0d reads want %0d", rdcnt[0], r); end
    tx_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (got0.size() !== s + 1 || txv[0] !== 1'b0) begin
      n_bad++; $display("FAIL bp_single_accept got %0d accepts valid=%b want 1 0", got0.size() - s, txv[0]);
    end
    for (int k = 0; k < 20 && (got0.size() < s + 2 || bsy[0] !== 1'b0); k++) @(negedge clk);
    n_cmp++; if (got0.size() !== s + 2) begin n_bad++; $display("FAIL bp_drain got %0d accepts want 2", got0.size() - s); end
    else begin
      n_cmp++; if (got0[s] !== 8'h51 || got0[s+1] !== 8'h41) begin
        n_bad++; $display("FAIL bp_bytes got %02h %02h want 51 41", got0[s], got0[s+1]);
      end
    end
  endtask

  task automatic test_en_drop;
    int s;
    int r;
    tx_ready = 1'b0;
    push(0, 8'h0D); push(0, 8'h78);
    for (int k = 0; k < 20 && txv[0] !== 1'b1; k++) @(negedge clk);
    n_cmp++; if (txv[0] !== 1'b1 || txd[0] !== 8'h0D) begin n_bad++; $display("FAIL endrop_send got valid=%b data=%02h want 1 0d", txv[0], txd[0]); end
    s = got0.size();
    r = rdcnt[0];
    en = 1'b0;
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && bsy[0] !== 1'b0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    n_cmp++; if (got0.size() !== s + 2) begin n_bad++; $display("FAIL endrop_len got %0d want 2", got0.size() - s); end
    else begin
      n_cmp++; if (got0[s] !== 8'h0D || got0[s+1] !== 8'h0A) begin
        n_bad++; $display("FAIL endrop_bytes got %02h %02h want 0d 0a", got0[s], got0[s+1]);
      end
    end
    n_cmp++; if (rdcnt[0] !== r) begin n_bad++; $display("FAIL endrop_no_fetch got %0d reads want %0d", rdcnt[0], r); end
    n_cmp++; if (bsy[0] !== 1'b0 || fe[0] !== 1'b0) begin n_bad++; $display("FAIL endrop_idle got busy=%b empty=%b want 0 0", bsy[0], fe[0]); end
  endtask

  task automatic test_reset_mid;
    int s;
    tx_ready = 1'b0;
    en = 1'b1;
    for (int k = 0; k < 20 && txv[0] !== 1'b1; k++) @(negedge clk);
    n_cmp++; if (txv[0] !== 1'b1 || txd[0] !== 8'h58) begin n_bad++; $display("FAIL rmid_send got valid=%b data=%02h want 1 58", txv[0], txd[0]); end
    push(0, 8'h63);
    s = got0.size();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (txv[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid got %b want 0", txv[0]); end
    n_cmp++; if (cnt0 !== 16'd0 || bsy[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_async_state got count=%0d busy=%b want 0 0", cnt0, bsy[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    for (int k = 0; k < 20 && got0.size() < s + 1; k++) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (got0.size() !== s + 1) begin n_bad++; $display("FAIL rmid_len got %0d want 1", got0.size() - s); end
    else begin
      n_cmp++; if (got0[s] !== 8'h43) begin n_bad++; $display("FAIL rmid_byte got %02h want 43", got0[s]); end
    end
    n_cmp++; if (cnt0 !== 16'd1) begin n_bad++; $display("FAIL rmid_count got %0d want 1", cnt0); end
  endtask

  task automatic test_count_wrap;
    tx_ready = 1'b1;
    en = 1'b1;
    for (int j = 0; j < 17; j++) push(2, 8'h30);
    for (int k = 0; k < 200 && got2.size() < 17; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++; if (got2.size() !== 17) begin n_bad++; $display("FAIL wrap_len got %0d want 17", got2.size()); end
    n_cmp++; if (cnt2 !== 4'd1) begin n_bad++; $display("FAIL wrap_count got %0d want 1", cnt2); end
    n_cmp++; if (bsy[2] !== 1'b0 || txd[2] !== 8'h30) begin n_bad++; $display("FAIL wrap_end got busy=%b data=%02h want 0 30", bsy[2], txd[2]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_cr_expand();
    test_backpressure();
    test_en_drop();
    test_reset_mid();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
